// File: rtl/unified_mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory.
package unified_mem_pkg;

    // Controller mode: normal CPU access or streaming program load.
    typedef enum logic {
        RUN,
        LOAD
    } mem_state_e;

    // Widest word the store-extension helper can produce.
    localparam int EXT_MAX_W = 32;

    // Widens a narrow store value of wdW bits to EXT_MAX_W bits, either
    // zero-filling or replicating bit wdW-1. Callers cast the result down
    // to their own word width.
    function automatic logic [EXT_MAX_W-1:0] ext(
        input logic [EXT_MAX_W-1:0] wd,
        input int                   wdW,
        input bit                   signExt
    );
        logic [EXT_MAX_W-1:0] mask;
        logic [EXT_MAX_W-1:0] res;
        logic                 signBit;
        if (wdW >= EXT_MAX_W) begin
            mask = '1;
        end else begin
            mask = (EXT_MAX_W'(1) << wdW) - EXT_MAX_W'(1);
        end
        signBit = |(wd & (EXT_MAX_W'(1) << (wdW - 1)));
        res     = wd & mask;
        if (signExt && signBit) begin
            res = res | ~mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/unified_mem_loader.sv
// Streaming loader controller: owns the RUN/LOAD mode, the fill pointer
// and the sticky overflow flag, and hands write requests to the memory.
module unified_mem_loader
    import unified_mem_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output mem_state_e        state,
    output logic              ld_ready,
    output logic              busy,
    output logic              ld_ovf,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data
);

    mem_state_e        stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;
    logic              ovf;
    logic              ovfNext;

    // Mode, pointer and overflow flag; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            ptr   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            ovf   <= ovfNext;
        end
    end

    // Next-mode logic; a restart pulse wins over a same-cycle transfer,
    // and the last slot without ld_last flags overflow instead of wrapping.
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        ovfNext   = ovf;
        wr_en     = 1'b0;
        if (ld_start) begin
            stateNext = LOAD;
            ptrNext   = '0;
            ovfNext   = 1'b0;
        end else if (state == LOAD && ld_valid) begin
            wr_en = rst_n;
            if (ld_last) begin
                stateNext = RUN;
            end else if (ptr == '1) begin
                ovfNext   = 1'b1;
                stateNext = RUN;
            end else begin
                ptrNext = ptr + 1'b1;
            end
        end
    end

    assign ld_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign ld_ovf   = ovf;
    assign wr_addr  = ptr;
    assign wr_data  = ld_data;

endmodule

// File: rtl/unified_mem_dp.sv
// Unified instruction/data memory: registered fetch port, registered
// load/store data port, and a streaming loader that fills from word 0.
module unified_mem_dp
    import unified_mem_pkg::*;
#(
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int WD_W     = 8,
    parameter int SIGN_EXT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_re,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [WD_W-1:0]   d_wd,
    input  logic              d_re,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_rvalid,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              ld_ovf
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    mem_state_e        state;
    logic              ldWe;
    logic [ADDR_W-1:0] ldAddr;
    logic [WORD_W-1:0] ldWdata;

    logic [WORD_W-1:0] storeWord;
    logic              storeEn;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [WORD_W-1:0] wrData;
    logic              ifAccept;
    logic              dAccept;
    logic [WORD_W-1:0] ifWord;
    logic [WORD_W-1:0] dWord;

    unified_mem_loader #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) loader (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .state    (state),
        .ld_ready (ld_ready),
        .busy     (busy),
        .ld_ovf   (ld_ovf),
        .wr_en    (ldWe),
        .wr_addr  (ldAddr),
        .wr_data  (ldWdata)
    );

    assign storeWord = WORD_W'(ext(EXT_MAX_W'(d_wd), WD_W, SIGN_EXT != 0));

    // Stores only count in RUN and out of reset; the loader owns the write
    // port whenever it has a word, so it takes priority in the mux.
    assign storeEn = d_we && (state == RUN) && rst_n;
    assign wrEn    = ldWe || storeEn;
    assign wrAddr  = ldWe ? ldAddr  : d_addr;
    assign wrData  = ldWe ? ldWdata : storeWord;

    // A start pulse claims the cycle, so requests alongside it are dropped.
    assign ifAccept = rst_n && (state == RUN) && !ld_start && if_re;
    assign dAccept  = rst_n && (state == RUN) && !ld_start && d_re;

    // Write-first bypass so a same-cycle read sees the word being written.
    assign ifWord = (wrEn && wrAddr == if_addr) ? wrData : mem[if_addr];
    assign dWord  = (wrEn && wrAddr == d_addr)  ? wrData : mem[d_addr];

    // Memory array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Registered read data and one-cycle valid strobes; data holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_rdata  <= '0;
            if_rvalid <= 1'b0;
            d_rdata   <= '0;
            d_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= ifAccept;
            d_rvalid  <= dAccept;
            if (ifAccept) begin
                if_rdata <= ifWord;
            end
            if (dAccept) begin
                d_rdata <= dWord;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_dp.sv
// Self-checking bench for unified_mem_dp: directed scenarios plus random
// traffic, compared every cycle against a behavioural memory model.
module tb_unified_mem_dp;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 6;
    localparam int WD_W   = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] if_addr;
    logic              if_re;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [WD_W-1:0]   d_wd;
    logic              d_re;
    logic              ld_start;
    logic              ld_valid;
    logic [WORD_W-1:0] ld_data;
    logic              ld_last;

    logic [WORD_W-1:0] ifRdata0, dRdata0, ifRdata1, dRdata1;
    logic              ifRvalid0, dRvalid0, ldReady0, busy0, ldOvf0;
    logic              ifRvalid1, dRvalid1, ldReady1, busy1, ldOvf1;

    int compared   = 0;
    int mismatched = 0;

    unified_mem_dp #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .WD_W(WD_W), .SIGN_EXT(0)) dutZero (
        .clk(clk), .rst_n(rst_n),
        .if_addr(if_addr), .if_re(if_re), .if_rdata(ifRdata0), .if_rvalid(ifRvalid0),
        .d_addr(d_addr), .d_we(d_we), .d_wd(d_wd), .d_re(d_re),
        .d_rdata(dRdata0), .d_rvalid(dRvalid0),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ldReady0), .busy(busy0), .ld_ovf(ldOvf0)
    );

    unified_mem_dp #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .WD_W(WD_W), .SIGN_EXT(1)) dutSign (
        .clk(clk), .rst_n(rst_n),
        .if_addr(if_addr), .if_re(if_re), .if_rdata(ifRdata1), .if_rvalid(ifRvalid1),
        .d_addr(d_addr), .d_we(d_we), .d_wd(d_wd), .d_re(d_re),
        .d_rdata(dRdata1), .d_rvalid(dRvalid1),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ldReady1), .busy(busy1), .ld_ovf(ldOvf1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural model state: memory images for both extension modes.
    logic [WORD_W-1:0] modelMem0 [DEPTH];
    logic [WORD_W-1:0] modelMem1 [DEPTH];
    bit                modelKnown [DEPTH];
    bit                modelValid = 1'b0;
    bit                modelLoading;
    bit                modelOvf;
    int                modelPtr;
    bit                expIfValid, expIfKnown, expDValid, expDKnown, expJustReset;
    logic [WORD_W-1:0] expIf0, expIf1, expD0, expD1;

    logic [WORD_W-1:0] loadWords [4] = '{16'hC201, 16'hC304, 16'hC403, 16'hC503};
    logic [WORD_W-1:0] firstWord, lastWord, abortWords [2];

    function automatic logic [WORD_W-1:0] modelExt(input logic [WD_W-1:0] v, input bit s);
        return s ? WORD_W'($signed(v)) : WORD_W'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        if_addr  = '0; if_re = 1'b0;
        d_addr   = '0; d_we  = 1'b0; d_wd = '0; d_re = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    endtask

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            modelValid   = 1'b1;
            modelLoading = 1'b0;
            modelPtr     = 0;
            modelOvf     = 1'b0;
            expIfValid   = 1'b0;
            expDValid    = 1'b0;
            expDKnown    = 1'b1;
            expD0        = '0;
            expD1        = '0;
            expJustReset = 1'b1;
        end else begin
            expJustReset = 1'b0;
            if (ld_start) begin
                modelLoading = 1'b1;
                modelPtr     = 0;
                modelOvf     = 1'b0;
                expIfValid   = 1'b0;
                expDValid    = 1'b0;
            end else if (modelLoading) begin
                expIfValid = 1'b0;
                expDValid  = 1'b0;
                if (ld_valid) begin
                    modelMem0[modelPtr]  = ld_data;
                    modelMem1[modelPtr]  = ld_data;
                    modelKnown[modelPtr] = 1'b1;
                    if (ld_last) begin
                        modelLoading = 1'b0;
                    end else if (modelPtr == DEPTH - 1) begin
                        modelOvf     = 1'b1;
                        modelLoading = 1'b0;
                    end else begin
                        modelPtr++;
                    end
                end
            end else begin
                if (d_we) begin
                    modelMem0[d_addr]  = modelExt(d_wd, 1'b0);
                    modelMem1[d_addr]  = modelExt(d_wd, 1'b1);
                    modelKnown[d_addr] = 1'b1;
                end
                expIfValid = if_re;
                if (if_re) begin
                    expIf0     = modelMem0[if_addr];
                    expIf1     = modelMem1[if_addr];
                    expIfKnown = modelKnown[if_addr];
                end
                expDValid = d_re;
                if (d_re) begin
                    expD0     = modelMem0[d_addr];
                    expD1     = modelMem1[d_addr];
                    expDKnown = modelKnown[d_addr];
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("busy0",     32'(busy0),     32'(modelLoading));
            checkOutput("ld_ready0", 32'(ldReady0),  32'(modelLoading));
            checkOutput("ld_ovf0",   32'(ldOvf0),    32'(modelOvf));
            checkOutput("busy1",     32'(busy1),     32'(modelLoading));
            checkOutput("ld_ovf1",   32'(ldOvf1),    32'(modelOvf));
            checkOutput("if_rvalid0", 32'(ifRvalid0), 32'(expIfValid));
            checkOutput("if_rvalid1", 32'(ifRvalid1), 32'(expIfValid));
            checkOutput("d_rvalid0",  32'(dRvalid0),  32'(expDValid));
            checkOutput("d_rvalid1",  32'(dRvalid1),  32'(expDValid));
            if (expIfValid && expIfKnown) begin
                checkOutput("if_rdata0", 32'(ifRdata0), 32'(expIf0));
                checkOutput("if_rdata1", 32'(ifRdata1), 32'(expIf1));
            end else if (expJustReset) begin
                checkOutput("if_rdata0_rst", 32'(ifRdata0), 32'h0);
                checkOutput("if_rdata1_rst", 32'(ifRdata1), 32'h0);
            end
            if (expDKnown) begin
                checkOutput("d_rdata0", 32'(dRdata0), 32'(expD0));
                checkOutput("d_rdata1", 32'(dRdata1), 32'(expD1));
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        clearInputs();
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_busy",     32'(busy0),     32'h0);
        checkOutput("rst_ld_ready", 32'(ldReady0),  32'h0);
        checkOutput("rst_if_rvalid", 32'(ifRvalid0), 32'h0);
        checkOutput("rst_d_rdata",  32'(dRdata0),   32'h0);
        rst_n = 1'b1;

        // Four-word program load.
        ld_start = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("load_busy_on", 32'(busy0), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = loadWords[i];
            ld_last  = (i == 3);
            applyStimulus();
            if (i == 2) checkOutput("load_busy_mid", 32'(busy0), 32'h1);
        end
        clearInputs();
        checkOutput("load_busy_off", 32'(busy0), 32'h0);
        for (int i = 0; i < 4; i++) begin
            if_re   = 1'b1;
            if_addr = ADDR_W'(i);
            applyStimulus();
            checkOutput("load_readback", 32'(ifRdata0), 32'(loadWords[i]));
        end
        clearInputs();

        // Narrow store extension.
        d_we = 1'b1; d_addr = 6'd10; d_wd = 8'h85;
        applyStimulus();
        clearInputs();
        d_re = 1'b1; d_addr = 6'd10;
        applyStimulus();
        clearInputs();
        checkOutput("ext_rvalid", 32'(dRvalid0), 32'h1);
        checkOutput("ext_zero",   32'(dRdata0),  32'h0085);
        checkOutput("ext_sign",   32'(dRdata1),  32'hFF85);
        applyStimulus();
        checkOutput("ext_rvalid_drop", 32'(dRvalid0), 32'h0);

        // Same-cycle store and reads on both ports.
        d_we = 1'b1; d_addr = 6'd7; d_wd = 8'h3C; d_re = 1'b1;
        if_re = 1'b1; if_addr = 6'd7;
        applyStimulus();
        clearInputs();
        checkOutput("rdw_fetch", 32'(ifRdata0), 32'h003C);
        checkOutput("rdw_data",  32'(dRdata0),  32'h003C);

        // Overflowing stream of DEPTH+1 words without ld_last.
        ld_start = 1'b1;
        applyStimulus();
        clearInputs();
        for (int i = 0; i <= DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_data  = WORD_W'($urandom);
            if (i == 0) firstWord = ld_data;
            if (i == DEPTH - 1) lastWord = ld_data;
            applyStimulus();
            if (i == DEPTH - 1) begin
                checkOutput("ovf_flag", 32'(ldOvf0), 32'h1);
                checkOutput("ovf_busy", 32'(busy0),  32'h0);
            end
        end
        clearInputs();
        if_re = 1'b1; if_addr = '0;
        applyStimulus();
        checkOutput("ovf_word0", 32'(ifRdata0), 32'(firstWord));
        if_addr = ADDR_W'(DEPTH - 1);
        applyStimulus();
        clearInputs();
        checkOutput("ovf_lastword", 32'(ifRdata0), 32'(lastWord));

        // Seeded word survives reset, and reset clears the sticky overflow.
        d_we = 1'b1; d_addr = 6'd5; d_wd = 8'h5A;
        applyStimulus();
        clearInputs();
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        checkOutput("rst_ovf_clear", 32'(ldOvf0), 32'h0);
        d_re = 1'b1; d_addr = 6'd5;
        applyStimulus();
        clearInputs();
        checkOutput("seed_survives", 32'(dRdata0), 32'h005A);

        // Randomized traffic, including requests that must be ignored in LOAD.
        for (int n = 0; n < 600; n++) begin
            clearInputs();
            if ($urandom_range(0, 99) < 3) begin
                ld_start = 1'b1;
            end else begin
                if (modelLoading) begin
                    ld_valid = 1'($urandom_range(0, 1));
                    ld_data  = WORD_W'($urandom);
                    ld_last  = ($urandom_range(0, 7) == 0);
                end
                if_re   = 1'($urandom_range(0, 1));
                d_re    = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                if_addr = ADDR_W'($urandom_range(0, 15));
                d_addr  = ADDR_W'($urandom_range(0, 15));
                d_wd    = WD_W'($urandom);
            end
            applyStimulus();
        end
        clearInputs();
        applyStimulus();
        while (modelLoading) begin
            ld_valid = 1'b1; ld_last = 1'b1; ld_data = 16'h1234;
            applyStimulus();
        end
        clearInputs();

        // Reset in the middle of a load.
        abortWords[0] = 16'hA0A0;
        abortWords[1] = 16'hB1B1;
        ld_start = 1'b1;
        applyStimulus();
        clearInputs();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = abortWords[i];
            applyStimulus();
        end
        clearInputs();
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("abort_busy", 32'(busy0), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_re = 1'b1; if_addr = ADDR_W'(i);
            applyStimulus();
            checkOutput("abort_rvalid", 32'(ifRvalid0), 32'h1);
            checkOutput("abort_word",   32'(ifRdata0),  32'(abortWords[i]));
        end
        clearInputs();
        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
